// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, fetches over a variable-latency req/resp port and fills IF/ID.
// Define FETCH_PERF_EN to add the FetchCountF / BubbleCountF performance counters.
module fetch_stage #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(32'h0000_0000),
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = WORD_SIZE'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCSrcE,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic [WORD_SIZE-1:0] PCF,
  output logic [WORD_SIZE-1:0] InstrD,
  output logic [WORD_SIZE-1:0] PCD,
  output logic [WORD_SIZE-1:0] PCPlus4D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          FetchCountF,
  output logic [31:0]          BubbleCountF
`endif
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_pcf;
  logic [WORD_SIZE-1:0] r_skid;
  logic [WORD_SIZE-1:0] r_instr_d;
  logic [WORD_SIZE-1:0] r_pc_d;
  logic [WORD_SIZE-1:0] r_pc_plus4_d;

  logic                 w_req;
  logic                 w_deliver;
  logic                 w_load_instr;
  logic                 w_load_bubble;
  logic [WORD_SIZE-1:0] w_fetch_word;
  logic [WORD_SIZE-1:0] w_pc_plus4;

  // Request strobe is held low throughout reset and whenever fetch is stalled.
  assign w_req     = rst && (r_state == S_REQ) && !StallF;
  assign imem_req  = w_req;
  assign imem_addr = r_pcf;

  // A fetch completes when a fresh word (from memory or skid) can enter IF/ID this edge.
  assign w_deliver     = !PCSrcE && !StallD &&
                         (((r_state == S_WAIT) && imem_rvalid) || (r_state == S_HOLD));
  assign w_load_instr  = w_deliver && !FlushD;
  assign w_load_bubble = PCSrcE || FlushD || (!StallD && !w_deliver);
  assign w_fetch_word  = (r_state == S_HOLD) ? r_skid : imem_rdata;
  assign w_pc_plus4    = r_pcf + WORD_SIZE'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_pcf        <= RESET_PC;
      r_skid       <= '0;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (PCSrcE)     r_state <= w_req ? S_DRAIN : S_REQ;
          else if (w_req) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A redirect in the same cycle as the response simply drops the response.
          if (imem_rvalid) begin
            if (PCSrcE || !StallD) begin
              r_state <= S_REQ;
            end else begin
              r_state <= S_HOLD;
              r_skid  <= imem_rdata;
            end
          end else if (PCSrcE) begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (PCSrcE || !StallD) r_state <= S_REQ;
        end
        S_DRAIN: begin
          // Once the stale response is consumed nothing is outstanding, even under a redirect.
          if (imem_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase

      if (PCSrcE)         r_pcf <= PCTargetE;
      else if (w_deliver) r_pcf <= w_pc_plus4;

      if (w_load_bubble) begin
        r_instr_d    <= NOP_INSTR;
        r_pc_d       <= '0;
        r_pc_plus4_d <= '0;
      end else if (w_load_instr) begin
        r_instr_d    <= w_fetch_word;
        r_pc_d       <= r_pcf;
        r_pc_plus4_d <= w_pc_plus4;
      end
    end
  end

  assign PCF      = r_pcf;
  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Free-running event counters; reset-time bubble loads are not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load_instr)  r_fetch_cnt  <= r_fetch_cnt + CNT_W'(1);
      if (w_load_bubble) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign FetchCountF  = r_fetch_cnt;
  assign BubbleCountF = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RSTPC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCountF;
  logic [31:0] BubbleCountF;
`endif

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D)
`ifdef FETCH_PERF_EN
    ,
    .FetchCountF (FetchCountF),
    .BubbleCountF(BubbleCountF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pcs, input logic [31:0] tgt,
                       input logic sf, input logic sd, input logic fd,
                       input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst = r; PCSrcE = pcs; PCTargetE = tgt; StallF = sf; StallD = sd; FlushD = fd;
    imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, pcs;
    logic [31:0] tgt;
    logic        sf, sd, fd, rv;
    logic [31:0] rd;
    logic        exp_req;
    logic [31:0] exp_addr, exp_pcf, exp_instr, exp_pcd, exp_p4;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic pcs, input logic [31:0] tgt,
                              input logic sf, input logic sd, input logic fd,
                              input logic rv, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic [31:0] pcf,
                              input logic [31:0] ins, input logic [31:0] pcd, input logic [31:0] p4);
    vec_t v;
    v.rst = r; v.pcs = pcs; v.tgt = tgt; v.sf = sf; v.sd = sd; v.fd = fd; v.rv = rv; v.rd = rd;
    v.exp_req = er; v.exp_addr = ea; v.exp_pcf = pcf; v.exp_instr = ins; v.exp_pcd = pcd; v.exp_p4 = p4;
    return v;
  endfunction

  // Behavioural model: outstanding/stale request flags and a skid slot instead of FSM states.
  logic [31:0] m_pc, m_skw, m_instr, m_pcd, m_p4, m_fc, m_bc;
  logic        m_out, m_stale, m_skv;

  task automatic model_step(input logic r, input logic pcs, input logic [31:0] tgt,
                            input logic sd, input logic fd, input logic rv,
                            input logic [31:0] rd, input logic req);
    logic        got, done;
    logic [31:0] w;
    if (!r) begin
      m_pc = RSTPC; m_out = 0; m_stale = 0; m_skv = 0;
      m_instr = NOP; m_pcd = 0; m_p4 = 0; m_fc = 0; m_bc = 0;
    end else begin
      got = m_out && rv;
      done = 0;
      w = 0;
      if (pcs) begin
        m_skv = 0;
      end else if (m_skv && !sd) begin
        done = 1; w = m_skw; m_skv = 0;
      end else if (got && !m_stale) begin
        if (!sd) begin
          done = 1; w = rd;
        end else begin
          m_skv = 1; m_skw = rd;
        end
      end
      if (pcs || fd || (!done && !sd)) begin
        m_instr = NOP; m_pcd = 0; m_p4 = 0; m_bc = m_bc + 1;
      end else if (done) begin
        m_instr = w; m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_fc = m_fc + 1;
      end
      if (got) m_out = 0;
      else if (pcs && m_out) m_stale = 1;
      if (req) begin
        m_out = 1; m_stale = pcs;
      end
      if (pcs) m_pc = tgt;
      else if (done) m_pc = m_pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        mem_busy, req_seen, r_in, pcs, sf, sd, fd, rv, exp_req;
    logic [31:0] mem_addr, req_addr, tgt, rd;
    int          mem_cnt;

    rst = 0; PCSrcE = 0; PCTargetE = 0; StallF = 0; StallD = 0; FlushD = 0;
    imem_rvalid = 0; imem_rdata = 0;

    // Reset, two fetches, skid under StallD, redirect with a stale response.
    vq.push_back(mk(0,0,0,        0,0,0, 0,0,            0,0,     0,         NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 0,0,            1,0,     0,         NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 1,32'hA,        0,0,     4,         32'hA,    0,     4));
    vq.push_back(mk(1,0,0,        0,0,0, 0,0,            1,4,     4,         NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 1,32'hB,        0,0,     8,         32'hB,    4,     8));
    vq.push_back(mk(1,0,0,        0,1,0, 0,0,            1,8,     8,         32'hB,    4,     8));
    vq.push_back(mk(1,0,0,        0,1,0, 1,32'hCC,       0,0,     8,         32'hB,    4,     8));
    vq.push_back(mk(1,0,0,        0,1,0, 0,0,            0,0,     8,         32'hB,    4,     8));
    vq.push_back(mk(1,0,0,        0,1,0, 0,0,            0,0,     8,         32'hB,    4,     8));
    vq.push_back(mk(1,0,0,        0,0,0, 0,0,            0,0,     32'hC,     32'hCC,   8,     32'hC));
    vq.push_back(mk(1,0,0,        0,0,0, 0,0,            1,32'hC, 32'hC,     NOP,      0,     0));
    vq.push_back(mk(1,1,32'h100,  0,0,0, 0,0,            0,0,     32'h100,   NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 0,0,            0,0,     32'h100,   NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 1,32'hDEAD,     0,0,     32'h100,   NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 0,0,            1,32'h100, 32'h100, NOP,      0,     0));
    vq.push_back(mk(1,0,0,        0,0,0, 1,32'h111,      0,0,     32'h104,   32'h111,  32'h100, 32'h104));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].pcs, vq[i].tgt, vq[i].sf, vq[i].sd, vq[i].fd, vq[i].rv, vq[i].rd);
      chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(vq[i].exp_req));
      if (vq[i].exp_req) chk($sformatf("v%0d.addr", i), imem_addr, vq[i].exp_addr);
      tick();
      chk($sformatf("v%0d.pcf", i),   PCF,      vq[i].exp_pcf);
      chk($sformatf("v%0d.instr", i), InstrD,   vq[i].exp_instr);
      chk($sformatf("v%0d.pcd", i),   PCD,      vq[i].exp_pcd);
      chk($sformatf("v%0d.pcp4", i),  PCPlus4D, vq[i].exp_p4);
    end

    // Redirect coinciding with the response: no drain cycle.
    drive(1,0,0, 0,0,0, 0,0);
    chk("sa.req", 32'(imem_req), 32'd1);
    chk("sa.addr", imem_addr, 32'h104);
    tick();
    drive(1,1,32'h200, 0,0,0, 1,32'hBAD);
    tick();
    chk("sa.instr", InstrD, NOP);
    chk("sa.pcf", PCF, 32'h200);
    drive(1,0,0, 0,0,0, 0,0);
    chk("sa.req2", 32'(imem_req), 32'd1);
    chk("sa.addr2", imem_addr, 32'h200);
    tick();
    drive(1,0,0, 0,0,0, 1,32'h222);
    tick();
    chk("sa.instr2", InstrD, 32'h222);
    chk("sa.pcd2", PCD, 32'h200);

    // PC wrap at the top of the address space; redirect while StallF holds the request.
    drive(1,1,32'hFFFF_FFFC, 1,0,0, 0,0);
    chk("sb.req_stallf", 32'(imem_req), 32'd0);
    tick();
    chk("sb.pcf", PCF, 32'hFFFF_FFFC);
    drive(1,0,0, 0,0,0, 0,0);
    chk("sb.addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1,0,0, 0,0,0, 1,32'h77);
    tick();
    chk("sb.instr", InstrD, 32'h77);
    chk("sb.pcd", PCD, 32'hFFFF_FFFC);
    chk("sb.pcp4", PCPlus4D, 32'h0);
    chk("sb.pcf_wrap", PCF, 32'h0);
    drive(1,0,0, 0,0,0, 0,0);
    chk("sb.req", 32'(imem_req), 32'd1);
    chk("sb.addr_wrap", imem_addr, 32'h0);
    tick();
    drive(1,0,0, 0,0,0, 1,32'h55);
    tick();
    drive(1,0,0, 0,0,0, 0,0);
    chk("sc.addr4", imem_addr, 32'h4);
    tick();

    // Reset while waiting; the late response after release must be ignored.
    drive(0,0,0, 0,0,0, 0,0);
    chk("sc.req_rst", 32'(imem_req), 32'd0);
    tick();
    chk("sc.pcf", PCF, RSTPC);
    chk("sc.instr", InstrD, NOP);
    chk("sc.pcd", PCD, 32'h0);
    drive(0,0,0, 0,0,0, 0,0);
    chk("sc.req_rst2", 32'(imem_req), 32'd0);
    tick();
    drive(1,0,0, 1,0,0, 1,32'hBAD);
    chk("sc.req_late", 32'(imem_req), 32'd0);
    tick();
    chk("sc.instr_late", InstrD, NOP);
    chk("sc.pcf_late", PCF, RSTPC);
    drive(1,0,0, 0,0,0, 0,0);
    chk("sc.req_after", 32'(imem_req), 32'd1);
    chk("sc.addr_after", imem_addr, RSTPC);
    tick();
    chk("sc.instr_wait", InstrD, NOP);
    drive(1,0,0, 0,0,0, 1,32'h99);
    tick();
    chk("sc.instr_new", InstrD, 32'h99);
    chk("sc.pcd_new", PCD, RSTPC);
    chk("sc.pcf_new", PCF, RSTPC + 32'd4);

    // Random traffic against the model, variable memory latency 1..4.
    drive(0,0,0, 0,0,0, 0,0);
    tick();
    model_step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    mem_busy = 0; mem_addr = 0; mem_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      r_in = ($urandom_range(0, 149) != 0);
      pcs  = ($urandom_range(0, 7) == 0);
      tgt  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      sf   = ($urandom_range(0, 3) == 0);
      sd   = ($urandom_range(0, 2) == 0);
      fd   = ($urandom_range(0, 9) == 0);
      rv   = mem_busy && (mem_cnt == 0);
      rd   = rv ? mem_word(mem_addr) : $urandom();
      drive(r_in, pcs, tgt, sf, sd, fd, rv, rd);
      exp_req = r_in && !m_out && !m_skv && !sf;
      chk($sformatf("r%0d.req", c), 32'(imem_req), 32'(exp_req));
      if (exp_req) chk($sformatf("r%0d.addr", c), imem_addr, m_pc);
      req_seen = imem_req;
      req_addr = imem_addr;
      if (req_seen && mem_busy) chk($sformatf("r%0d.single_issue", c), 32'(req_seen && mem_busy), 32'd0);
      tick();
      model_step(r_in, pcs, tgt, sd, fd, rv, rd, exp_req);
      if (!r_in) begin
        mem_busy = 0;
      end else begin
        if (rv) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (req_seen) begin
          mem_busy = 1; mem_addr = req_addr; mem_cnt = $urandom_range(0, 3);
        end
      end
      chk($sformatf("r%0d.pcf", c),   PCF,      m_pc);
      chk($sformatf("r%0d.instr", c), InstrD,   m_instr);
      chk($sformatf("r%0d.pcd", c),   PCD,      m_pcd);
      chk($sformatf("r%0d.pcp4", c),  PCPlus4D, m_p4);
`ifdef FETCH_PERF_EN
      chk($sformatf("r%0d.fetch_cnt", c),  FetchCountF,  m_fc);
      chk($sformatf("r%0d.bubble_cnt", c), BubbleCountF, m_bc);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
